// File: rtl/acc_rsp_arbiter.sv
// -----------------------------------------------------------------------------
// acc_rsp_arbiter
//
// Round-robin arbiter for the accelerator result (p) channel. Merges the
// result responses of NumRsp accelerator responders onto the single result
// port that feeds the core's X-interface writeback. The output is fully
// registered (one pipeline stage). out_src_o reports which responder
// produced the current result.
//
// Parameters:
//   NumRsp    - number of responders arbitrated (>= 1)
//   DataWidth - result data width
//   SrcW      - width of the source index (derived, not overridable)
//
// Ports:
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset
//   rsp_valid_i  in   [NumRsp]           per-responder result valid
//   rsp_ready_o  out  [NumRsp]           per-responder ready (one-hot or zero)
//   rsp_rd_i     in   [NumRsp*5]         destination register, responder i at [5i+:5]
//   rsp_data_i   in   [NumRsp*DataWidth] result data, responder i at [DataWidth*i+:DataWidth]
//   rsp_error_i  in   [NumRsp]           per-responder error flag
//   out_valid_o  out  merged result valid
//   out_ready_i  in   merged result ready (core p_ready)
//   out_rd_o     out  [5]          merged destination register
//   out_data_o   out  [DataWidth]  merged result data
//   out_error_o  out  merged error flag
//   out_src_o    out  [SrcW]       index of the responder that produced the output
// -----------------------------------------------------------------------------
module acc_rsp_arbiter #(
  parameter  int NumRsp    = 2,
  parameter  int DataWidth = 32,
  localparam int SrcW      = (NumRsp > 1) ? $clog2(NumRsp) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumRsp-1:0]         rsp_valid_i,
  output logic [NumRsp-1:0]         rsp_ready_o,
  input  logic [NumRsp*5-1:0]       rsp_rd_i,
  input  logic [NumRsp*DataWidth-1:0] rsp_data_i,
  input  logic [NumRsp-1:0]         rsp_error_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [4:0]                out_rd_o,
  output logic [DataWidth-1:0]      out_data_o,
  output logic                      out_error_o,
  output logic [SrcW-1:0]           out_src_o
);

  localparam logic [SrcW-1:0] LastIdx = SrcW'(NumRsp - 1);

  // Output register and round-robin pointer
  logic                 r_valid;
  logic [4:0]           r_rd;
  logic [DataWidth-1:0] r_data;
  logic                 r_error;
  logic [SrcW-1:0]      r_src;
  logic [SrcW-1:0]      r_ptr;

  logic                 w_load_en;
  logic                 w_any;
  logic                 w_hs;
  logic [SrcW-1:0]      w_grant;
  logic [SrcW-1:0]      w_idx;
  logic [4:0]           w_sel_rd;
  logic [DataWidth-1:0] w_sel_data;
  logic                 w_sel_error;
  logic [SrcW-1:0]      w_ptr_next;

  // The output slot can accept a new result when it is empty or being
  // drained this cycle; nothing is accepted while reset is asserted.
  assign w_load_en = rst_ni && (!out_valid_o || out_ready_i);
  assign w_hs      = w_load_en && w_any;

  // Grant: first requesting responder scanning from r_ptr upward with wrap.
  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NumRsp; k++) begin
      w_idx = SrcW'((int'(r_ptr) + k) % NumRsp);
      if (!w_any && rsp_valid_i[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Field mux for the granted responder
  always_comb begin
    w_sel_rd    = '0;
    w_sel_data  = '0;
    w_sel_error = 1'b0;
    for (int i = 0; i < NumRsp; i++) begin
      if (w_grant == SrcW'(i)) begin
        w_sel_rd    = rsp_rd_i[5*i +: 5];
        w_sel_data  = rsp_data_i[DataWidth*i +: DataWidth];
        w_sel_error = rsp_error_i[i];
      end
    end
  end

  assign w_ptr_next  = (w_grant == LastIdx) ? '0 : w_grant + 1'b1;
  assign rsp_ready_o = w_hs ? (NumRsp'(1) << w_grant) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  // NOTE: all state here is a handful of flops, so every register is reset;
  // a reset is only worth skipping on wide storage arrays.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_error <= 1'b0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else if (w_load_en) begin
      // Empty or draining: refill on a handshake, otherwise go empty while
      // the data fields keep their last value.
      r_valid <= w_any;
      if (w_any) begin
        r_rd    <= w_sel_rd;
        r_data  <= w_sel_data;
        r_error <= w_sel_error;
        r_src   <= w_grant;
        r_ptr   <= w_ptr_next;
      end
    end
  end

  assign out_valid_o = r_valid;
  assign out_rd_o    = r_rd;
  assign out_data_o  = r_data;
  assign out_error_o = r_error;
  assign out_src_o   = r_src;

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_ready_o));

  a_out_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_valid && !out_ready_i) |=>
      (r_valid && $stable(r_rd) && $stable(r_data) && $stable(r_error) && $stable(r_src)));

  a_ptr_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(r_ptr) < NumRsp);

  for (genvar i = 0; i < NumRsp; i++) begin : g_proto
    a_req_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rsp_valid_i[i] && !rsp_ready_o[i]) |=>
        (rsp_valid_i[i] && $stable(rsp_rd_i[5*i +: 5]) &&
         $stable(rsp_data_i[DataWidth*i +: DataWidth]) && $stable(rsp_error_i[i])));
  end
`endif

endmodule

// File: tb/tb_acc_rsp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_acc_rsp_arbiter
//
// Bench for acc_rsp_arbiter. Two instances are exercised side by side:
// index 0 is NumRsp=2, index 1 is NumRsp=4. Responder requests are held in
// bench arrays; a reference model tracks the expected output slot and the
// round-robin pointer and is compared against both instances every cycle.
// -----------------------------------------------------------------------------
module tb_acc_rsp_arbiter;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // Requests per instance (index 0: 2 responders, index 1: 4 responders)
  bit          tv   [2][4];
  logic [4:0]  trd  [2][4];
  logic [31:0] tdat [2][4];
  bit          terr [2][4];
  bit          tout [2];

  // Instance 0 (NumRsp = 2)
  logic [1:0]  a_valid, a_ready, a_err;
  logic [9:0]  a_rd;
  logic [63:0] a_data;
  logic        a_ov, a_oready, a_oerr;
  logic [4:0]  a_ord;
  logic [31:0] a_odata;
  logic [0:0]  a_src;

  // Instance 1 (NumRsp = 4)
  logic [3:0]   b_valid, b_ready, b_err;
  logic [19:0]  b_rd;
  logic [127:0] b_data;
  logic         b_ov, b_oready, b_oerr;
  logic [4:0]   b_ord;
  logic [31:0]  b_odata;
  logic [1:0]   b_src;

  always_comb begin
    a_valid = '0; a_rd = '0; a_data = '0; a_err = '0;
    for (int i = 0; i < 2; i++) begin
      a_valid[i]        = tv[0][i];
      a_rd[5*i +: 5]    = trd[0][i];
      a_data[32*i +: 32] = tdat[0][i];
      a_err[i]          = terr[0][i];
    end
  end

  always_comb begin
    b_valid = '0; b_rd = '0; b_data = '0; b_err = '0;
    for (int i = 0; i < 4; i++) begin
      b_valid[i]        = tv[1][i];
      b_rd[5*i +: 5]    = trd[1][i];
      b_data[32*i +: 32] = tdat[1][i];
      b_err[i]          = terr[1][i];
    end
  end

  assign a_oready = tout[0];
  assign b_oready = tout[1];

  acc_rsp_arbiter #(.NumRsp(2), .DataWidth(32)) u_dut2 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rsp_valid_i (a_valid),
    .rsp_ready_o (a_ready),
    .rsp_rd_i    (a_rd),
    .rsp_data_i  (a_data),
    .rsp_error_i (a_err),
    .out_valid_o (a_ov),
    .out_ready_i (a_oready),
    .out_rd_o    (a_ord),
    .out_data_o  (a_odata),
    .out_error_o (a_oerr),
    .out_src_o   (a_src)
  );

  acc_rsp_arbiter #(.NumRsp(4), .DataWidth(32)) u_dut4 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rsp_valid_i (b_valid),
    .rsp_ready_o (b_ready),
    .rsp_rd_i    (b_rd),
    .rsp_data_i  (b_data),
    .rsp_error_i (b_err),
    .out_valid_o (b_ov),
    .out_ready_i (b_oready),
    .out_rd_o    (b_ord),
    .out_data_o  (b_odata),
    .out_error_o (b_oerr),
    .out_src_o   (b_src)
  );

  // Reference model: the result currently presented and the responder that
  // has first claim on the next grant.
  bit          m_val  [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_data [2];
  bit          m_err  [2];
  int          m_src  [2];
  int          m_ptr  [2];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic int nresp(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Responder served next: the first requester in round-robin order
  // starting from the one with first claim; -1 when nobody requests.
  function automatic int model_grant(input int d);
    int n;
    n = nresp(d);
    for (int k = 0; k < n; k++) begin
      if (tv[d][(m_ptr[d] + k) % n]) return (m_ptr[d] + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_val[d] = 1'b0; m_rd[d] = '0; m_data[d] = '0;
      m_err[d] = 1'b0; m_src[d] = 0;  m_ptr[d] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int d, input int i);
    tv[d][i]   = 1'b1;
    trd[d][i]  = 5'($urandom);
    tdat[d][i] = $urandom;
    terr[d][i] = 1'($urandom_range(0, 1));
  endtask

  task automatic check_dut(input int d);
    int         g;
    bit         ld;
    logic [3:0] erdy, ordy;
    logic       ov, oe;
    logic [4:0] ord;
    logic [31:0] od;
    int         os;
    g    = model_grant(d);
    ld   = !m_val[d] || tout[d];
    erdy = (rst_ni && ld && g >= 0) ? 4'(1 << g) : 4'b0000;
    if (d == 0) begin
      ordy = {2'b00, a_ready}; ov = a_ov; ord = a_ord; od = a_odata; oe = a_oerr; os = int'(a_src);
    end else begin
      ordy = b_ready; ov = b_ov; ord = b_ord; od = b_odata; oe = b_oerr; os = int'(b_src);
    end
    chk($sformatf("n%0d.rsp_ready", nresp(d)), 64'(ordy), 64'(erdy));
    chk($sformatf("n%0d.out_valid", nresp(d)), 64'(ov), 64'(m_val[d]));
    chk($sformatf("n%0d.out_rd", nresp(d)), 64'(ord), 64'(m_rd[d]));
    chk($sformatf("n%0d.out_data", nresp(d)), 64'(od), 64'(m_data[d]));
    chk($sformatf("n%0d.out_error", nresp(d)), 64'(oe), 64'(m_err[d]));
    chk($sformatf("n%0d.out_src", nresp(d)), 64'(os), 64'(m_src[d]));
  endtask

  // One clock: compare at the falling edge, let the DUT take the rising
  // edge, then advance the model and retire the served requests.
  task automatic step();
    int g [2];
    bit ld [2];
    bit in_rst;
    @(negedge clk_i);
    in_rst = !rst_ni;
    for (int d = 0; d < 2; d++) begin
      check_dut(d);
      g[d]  = model_grant(d);
      ld[d] = !m_val[d] || tout[d];
    end
    @(posedge clk_i);
    #1;
    if (!in_rst) begin
      for (int d = 0; d < 2; d++) begin
        if (ld[d] && g[d] >= 0) begin
          m_val[d]  = 1'b1;
          m_rd[d]   = trd[d][g[d]];
          m_data[d] = tdat[d][g[d]];
          m_err[d]  = terr[d][g[d]];
          m_src[d]  = g[d];
          m_ptr[d]  = (g[d] + 1) % nresp(d);
          tv[d][g[d]] = 1'b0;
        end else if (ld[d]) begin
          m_val[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic clear_reqs(input int d);
    for (int i = 0; i < 4; i++) tv[d][i] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        tv[d][i] = 1'b0; trd[d][i] = '0; tdat[d][i] = '0; terr[d][i] = 1'b0;
      end
      tout[d] = 1'b1;
    end
    model_reset();

    // Reset values
    #12;
    chk("rst.n2.out_valid", 64'(a_ov), 64'd0);
    chk("rst.n4.out_valid", 64'(b_ov), 64'd0);
    chk("rst.n4.out_src", 64'(b_src), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();

    // Single request from responder 1; pointer wraps back to 0
    tv[0][1] = 1'b1; trd[0][1] = 5'd5; tdat[0][1] = 32'hDEADBEEF; terr[0][1] = 1'b0;
    #1;
    chk("single.rsp_ready", 64'(a_ready), 64'b10);
    step();
    chk("single.out_valid", 64'(a_ov), 64'd1);
    chk("single.out_rd", 64'(a_ord), 64'd5);
    chk("single.out_data", 64'(a_odata), 64'hDEADBEEF);
    chk("single.out_src", 64'(a_src), 64'd1);

    // Both responders requesting every cycle: alternate with no bubbles
    new_req(0, 0); new_req(0, 1);
    #1;
    chk("wrap.rsp_ready", 64'(a_ready), 64'b01);
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 2; i++) if (!tv[0][i]) new_req(0, i);
      step();
      chk("stream.out_valid", 64'(a_ov), 64'd1);
      chk("stream.out_src", 64'(a_src), 64'(c % 2));
    end

    // Backpressure for 3 cycles while both request
    tout[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 2; i++) if (!tv[0][i]) new_req(0, i);
      #1;
      chk("stall.rsp_ready", 64'(a_ready), 64'd0);
      step();
    end
    tout[0] = 1'b1;
    repeat (3) step();

    // Error result forwarded unchanged, then the output drains
    clear_reqs(0);
    tv[0][0] = 1'b1; trd[0][0] = 5'd0; tdat[0][0] = 32'd0; terr[0][0] = 1'b1;
    step();
    chk("err.out_valid", 64'(a_ov), 64'd1);
    chk("err.out_error", 64'(a_oerr), 64'd1);
    chk("err.out_rd", 64'(a_ord), 64'd0);
    step();
    chk("err.drained", 64'(a_ov), 64'd0);

    // Four responders: move the pointer to 3, then wrap to 0 and on to 2
    tout[1] = 1'b1;
    new_req(1, 2);
    step();
    new_req(1, 0); new_req(1, 2);
    #1;
    chk("n4.wrap.rsp_ready", 64'(b_ready), 64'b0001);
    step();
    #1;
    chk("n4.next.rsp_ready", 64'(b_ready), 64'b0100);
    step();
    chk("n4.next.out_src", 64'(b_src), 64'd2);
    step();

    // Asynchronous reset while results are held and requests pending
    for (int i = 0; i < 2; i++) new_req(0, i);
    for (int i = 0; i < 4; i++) new_req(1, i);
    step();
    tout[0] = 1'b0; tout[1] = 1'b0;
    step();
    chk("prerst.n2.out_valid", 64'(a_ov), 64'd1);
    chk("prerst.n4.out_valid", 64'(b_ov), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    chk("rst.async.n2.out_valid", 64'(a_ov), 64'd0);
    chk("rst.async.n2.out_data", 64'(a_odata), 64'd0);
    chk("rst.async.n4.out_valid", 64'(b_ov), 64'd0);
    chk("rst.async.n4.out_src", 64'(b_src), 64'd0);
    chk("rst.async.n4.rsp_ready", 64'(b_ready), 64'd0);
    tout[0] = 1'b1; tout[1] = 1'b1;
    repeat (2) step();
    rst_ni = 1'b1;
    repeat (6) step();

    // Randomised traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nresp(d); i++) begin
          if (!tv[d][i] && $urandom_range(0, 99) < 50) new_req(d, i);
        end
        tout[d] = ($urandom_range(0, 99) < 70);
      end
      step();
    end

    // Drain everything still pending
    tout[0] = 1'b1; tout[1] = 1'b1;
    repeat (8) step();
    chk("final.n2.out_valid", 64'(a_ov), 64'd0);
    chk("final.n4.out_valid", 64'(b_ov), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_rsp_arbiter.md
Name: acc_rsp_arbiter

Overview:
Round-robin arbiter for the accelerator result (p) channel. Merges result responses from NumRsp accelerator responders onto the single result port that feeds the core's X-interface writeback (rd, data, error). Output is fully registered (one pipeline stage) and reports which responder produced each result. Instantiated between the per-accelerator result channels and the adapter's result input.

Parameters:
NumRsp, 2, number of responders arbitrated (>=1)
DataWidth, 32, result data width
SrcW, (NumRsp>1 ? $clog2(NumRsp) : 1), width of source index (derived, not overridable)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
rsp_valid_i  input  NumRsp  per-responder result valid
rsp_ready_o  output  NumRsp  per-responder result ready (one-hot or zero)
rsp_rd_i  input  NumRsp*5  per-responder destination register, responder i at [5i+:5]
rsp_data_i  input  NumRsp*DataWidth  per-responder result data, responder i at [DataWidth*i+:DataWidth]
rsp_error_i  input  NumRsp  per-responder error flag
out_valid_o  output  1  merged result valid
out_ready_i  input  1  merged result ready (core p_ready)
out_rd_o  output  5  merged destination register
out_data_o  output  DataWidth  merged result data
out_error_o  output  1  merged error flag
out_src_o  output  SrcW  index of responder that produced current output

Behaviour:
- One clock (clk_i); reset asynchronous, active-low (rst_ni), all state cleared on assertion.
- Reset values: out_valid_o=0, out_rd_o=0, out_data_o=0, out_error_o=0, out_src_o=0, rr pointer ptr_q=0; rsp_ready_o=0 while in reset.
- State: output register (valid, rd, data, error, src) + ptr_q (SrcW bits, range 0..NumRsp-1).
- load_en = !out_valid_o || out_ready_i.
- Grant g (combinational): first i with rsp_valid_i[i]=1 scanning ptr_q, ptr_q+1, ..., NumRsp-1, 0, ..., ptr_q-1.
- rsp_ready_o[g]=1 iff load_en and any rsp_valid_i; all other bits 0. rsp_ready_o may depend on rsp_valid_i; at most one bit set per cycle.
- On handshake at g: next cycle out_valid_o=1, out_rd/data/error = responder g fields, out_src_o=g; ptr_q <= (g==NumRsp-1) ? 0 : g+1.
- No handshake and out_valid_o && out_ready_i: out_valid_o<=0; data/rd/error/src registers hold last value; ptr_q unchanged.
- out_valid_o && !out_ready_i: all outputs held stable, no rsp_ready_o asserted, ptr_q unchanged.
- Latency: handshake at input cycle N -> out_valid_o at N+1. Throughput: 1 result/cycle; drain and load in same cycle produce no bubble.
- Idle (no rsp_valid_i): ptr_q unchanged, no state change beyond draining.
- NumRsp=1: ptr_q constant 0, out_src_o=0, block behaves as single-entry pipeline register.
- Reset mid-transfer: registered result discarded; responder not yet acknowledged keeps its request and is served after reset.
- Upstream protocol (asserted in simulation): once rsp_valid_i[i] rises it stays high with stable rd/data/error until rsp_ready_o[i]. Internal assertions: $onehot0(rsp_ready_o); output stable while out_valid_o && !out_ready_i; ptr_q < NumRsp.
- rd and error carried unmodified; no arithmetic on data.

Test Plan:
1. Reset asserted mid-activity with out_valid_o=1 -> all outputs 0 and ptr_q=0 immediately (async); after release, out_valid_o stays 0 until new request.
2. NumRsp=2, responder 1 valid rd=5 data=0xDEADBEEF error=0, out_ready_i=1 -> rsp_ready_o=2'b10 same cycle; next cycle out_valid_o=1, rd=5, data=0xDEADBEEF, src=1; ptr_q wraps to 0.
3. Both responders valid every cycle, out_ready_i=1 -> out_src_o sequence 0,1,0,1,... one result per cycle, no bubbles.
4. Output held with out_ready_i=0 for 3 cycles while both request -> rsp_ready_o=0, outputs stable; on out_ready_i=1 the next grant (per ptr_q) occurs that same cycle and new result appears the following cycle.
5. NumRsp=4, ptr_q=3, valid on responders 0 and 2 -> grant 0 (wrap), ptr_q becomes 1; next cycle responder 2 granted, ptr_q becomes 3.
6. Responder 0 error=1 rd=0 data=0 -> out_error_o=1, out_rd_o=0 forwarded unchanged; out_valid_o drops the cycle after consumption with no further requests.
